ysyx_ifu: RTL and testbench

Instruction fetch unit, directly downstream of the PC register. It accepts one PC per fetch and issues a single-beat read to instruction memory over an AXI-lite-style AR/R channel pair. It then presents {pc, inst, err} to the decode stage with a valid/ready handshake. It supports a flush/redirect that abandons any in-flight fetch.

---
 rtl/ysyx_ifu_if.sv | 49 ++++
 rtl/ysyx_ifu.sv | 171 +++++++++++++++++
 tb/tb_ysyx_ifu.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_ifu_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_ifu_if                                                   |
// | Purpose  : Bundles the fetch unit's PC-input, memory AR/R and decode-    |
// |            output handshakes into one interface.                         |
// | Modports : master - the fetch unit (drives pc_ready, AR request, rready, |
// |                     and the decode-side result)                          |
// |            slave  - the environment (PC stage, memory, decode)           |
// | Signals  : pc_valid/pc/pc_ready, flush,                                  |
// |            arvalid/araddr/arready, rvalid/rdata/rresp/rready,            |
// |            out_valid/out_ready/out_pc/out_inst/out_err                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ysyx_ifu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // PC stage side
   logic              pc_valid;
   logic [ADDR_W-1:0] pc;
   logic              pc_ready;
   logic              flush;
   // Instruction memory read address channel
   logic              arvalid;
   logic [ADDR_W-1:0] araddr;
   logic              arready;
   // Instruction memory read data channel
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rready;
   // Decode side
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic [DATA_W-1:0] out_inst;
   logic              out_err;

   modport master (
      input  pc_valid, pc, flush, arready, rvalid, rdata, rresp, out_ready,
      output pc_ready, arvalid, araddr, rready, out_valid, out_pc, out_inst, out_err
   );

   modport slave (
      output pc_valid, pc, flush, arready, rvalid, rdata, rresp, out_ready,
      input  pc_ready, arvalid, araddr, rready, out_valid, out_pc, out_inst, out_err
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_ifu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ysyx_ifu                                                      |
// | Purpose  : Instruction fetch unit. Accepts one PC at a time, issues a    |
// |            single-beat AR/R read to instruction memory and presents      |
// |            {pc, inst, err} to decode with a valid/ready handshake.       |
// |            A flush abandons the fetch in flight.                         |
// | Ports    : clk  - clock, rising edge                                     |
// |            rst  - asynchronous reset, active low                         |
// |            bus  - ysyx_ifu_if.master (PC in, AR/R memory, decode out)    |
// |            perf_fetch_cnt / perf_stall_cnt - only with IFU_PERF_EN       |
// | Options  : IFU_PERF_EN - adds fetch-handshake and REQ/WAIT stall         |
// |            counters as extra outputs                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ysyx_ifu #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic          clk,
   input  logic          rst,
   ysyx_ifu_if.master    bus
`ifdef IFU_PERF_EN
   ,
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_flush_seen;   // flush observed while the AR was still pending
   logic                r_arvalid;
   logic [ADDR_W-1:0]   r_araddr;
   logic                r_rready;
   logic                r_out_valid;
   logic [ADDR_W-1:0]   r_out_pc;
   logic [DATA_W-1:0]   r_out_inst;
   logic                r_out_err;

   logic                w_misaligned;
   logic                w_kill;

   assign w_misaligned = (bus.pc[1:0] != 2'b00);
   // Either a live flush or one remembered from REQ kills the pending response.
   assign w_kill       = bus.flush | r_flush_seen;

   assign bus.pc_ready  = (r_state == S_IDLE) & ~bus.flush;
   assign bus.arvalid   = r_arvalid;
   assign bus.araddr    = r_araddr;
   assign bus.rready    = r_rready;
   // A flush in HOLD must suppress the handshake in the same cycle.
   assign bus.out_valid = r_out_valid & ~bus.flush;
   assign bus.out_pc    = r_out_pc;
   assign bus.out_inst  = r_out_inst;
   assign bus.out_err   = r_out_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_flush_seen <= 1'b0;
         r_arvalid    <= 1'b0;
         r_araddr     <= '0;
         r_rready     <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_pc     <= RESET_PC;
         r_out_inst   <= '0;
         r_out_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.pc_valid && !bus.flush) begin
                  r_out_pc <= bus.pc;
                  if (w_misaligned) begin
                     // Fault is reported without touching memory.
                     r_out_inst  <= '0;
                     r_out_err   <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_araddr     <= bus.pc;
                     r_arvalid    <= 1'b1;
                     r_flush_seen <= 1'b0;
                     r_state      <= S_REQ;
                  end
               end
            end

            S_REQ: begin
               // The request is never withdrawn; a flush only marks the
               // eventual response for disposal.
               if (bus.flush) begin
                  r_flush_seen <= 1'b1;
               end
               if (bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= w_kill ? S_DROP : S_WAIT;
               end
            end

            S_WAIT: begin
               if (w_kill) begin
                  if (bus.rvalid) begin
                     r_rready <= 1'b0;
                     r_state  <= S_IDLE;
                  end else begin
                     r_state  <= S_DROP;
                  end
               end else if (bus.rvalid) begin
                  r_out_inst  <= bus.rdata;
                  r_out_err   <= (bus.rresp != 2'b00);
                  r_out_valid <= 1'b1;
                  r_rready    <= 1'b0;
                  r_state     <= S_HOLD;
               end
            end

            S_DROP: begin
               if (bus.rvalid) begin
                  r_rready <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end

            S_HOLD: begin
               if (bus.flush || bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef IFU_PERF_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
         end
         if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_ifu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ysyx_ifu                                                   |
// | Purpose  : Self-checking bench for ysyx_ifu. Directed fetches push their |
// |            expected {pc, inst, err} into a queue; a monitor pops and     |
// |            compares on every decode-side handshake. A small memory       |
// |            responder answers AR requests with configurable stall.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ysyx_ifu;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;

   ysyx_ifu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IFU_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   ysyx_ifu #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h8000_0000)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef IFU_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   // Monitor-maintained event counters
   int   ar_cycles   = 0;
   int   ar_unstable = 0;
   int   r_hs_cnt    = 0;
   int   ov_cycles   = 0;
   int   hs_cnt      = 0;
   logic ar_hs_s     = 1'b0;
   logic r_hs_s      = 1'b0;
   logic ar_prev     = 1'b0;
   logic [31:0] ar_addr_prev = '0;

   // Memory responder knobs
   int          mem_ar_stall = 0;
   logic [31:0] mem_rdata    = '0;
   logic [1:0]  mem_rresp    = 2'b00;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            ar_hs_s = 1'b0;
            r_hs_s  = 1'b0;
            ar_prev = 1'b0;
         end else begin
            if (bus.arvalid) begin
               ar_cycles++;
               if (ar_prev && (bus.araddr !== ar_addr_prev)) ar_unstable++;
            end
            ar_prev      = bus.arvalid;
            ar_addr_prev = bus.araddr;
            ar_hs_s      = bus.arvalid & bus.arready;
            r_hs_s       = bus.rvalid & bus.rready;
            if (r_hs_s) r_hs_cnt++;
            if (bus.out_valid) ov_cycles++;
            if (bus.out_valid && bus.out_ready) begin
               hs_cnt++;
               if (q.size() == 0) begin
                  check("unexpected_out", 96'd1, 96'd0);
               end else begin
                  e = q.pop_front();
                  check("out_bundle", {31'd0, bus.out_pc, bus.out_inst, bus.out_err},
                        {31'd0, e.pc, e.inst, e.err});
               end
            end
         end
      end
   end

   // Memory responder: drives AR/R inputs just after the rising edge.
   initial begin
      int stall;
      stall       = 0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rresp   = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            bus.arready = 1'b0;
            bus.rvalid  = 1'b0;
            stall       = 0;
         end else begin
            if (r_hs_s) bus.rvalid = 1'b0;
            if (ar_hs_s) begin
               bus.arready = 1'b0;
               bus.rvalid  = 1'b1;
               bus.rdata   = mem_rdata;
               bus.rresp   = mem_rresp;
               stall       = 0;
            end else if (bus.arvalid) begin
               if (stall < mem_ar_stall) begin
                  bus.arready = 1'b0;
                  stall++;
               end else begin
                  bus.arready = 1'b1;
               end
            end
         end
      end
   end

   // Offer one PC; returns one cycle later, just after the accepting edge.
   task automatic issue_pc(input logic [31:0] p);
      bus.pc_valid = 1'b1;
      bus.pc       = p;
      @(negedge clk);
      check("pc_ready_at_issue", {95'd0, bus.pc_ready}, 96'd1);
      @(posedge clk);
      #1;
      bus.pc_valid = 1'b0;
   endtask

   // Counts cycles from the accepting cycle (0) to out_valid; returns on that negedge.
   task automatic wait_out(input int exp_lat, input string nm);
      int lat;
      bit got;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
         lat++;
      end
      if (!got) check({nm, "_timeout"}, 96'd1, 96'd0);
      else      check({nm, "_latency"}, 96'(lat), 96'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ar0, hs0, ov0, rh0;
      logic [31:0] perf0;
      perf0         = '0;
      rst           = 1'b0;
      bus.pc_valid  = 1'b0;
      bus.pc        = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_arvalid",   {95'd0, bus.arvalid},   96'd0);
      check("rst_rready",    {95'd0, bus.rready},    96'd0);
      check("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
      check("rst_out_err",   {95'd0, bus.out_err},   96'd0);
      check("rst_araddr",    {64'd0, bus.araddr},    96'd0);
      check("rst_out_inst",  {64'd0, bus.out_inst},  96'd0);
      check("rst_out_pc",    {64'd0, bus.out_pc},    96'h8000_0000);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Minimum-latency fetch
      mem_rdata = 32'h0000_0413;
      q.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0413, err: 1'b0});
      issue_pc(32'h8000_0000);
      wait_out(3, "t1");
      @(posedge clk); #1;
      @(negedge clk);
      check("t1_pc_ready_after", {95'd0, bus.pc_ready},  96'd1);
      check("t1_out_valid_low",  {95'd0, bus.out_valid}, 96'd0);
      @(posedge clk); #1;

      // AR stall of 3 cycles, then decode backpressure for 2 cycles
      bus.out_ready = 1'b0;
      mem_ar_stall  = 3;
      mem_rdata     = 32'h0010_0093;
      ar0 = ar_cycles; hs0 = hs_cnt;
      q.push_back('{pc: 32'h8000_0004, inst: 32'h0010_0093, err: 1'b0});
      issue_pc(32'h8000_0004);
      wait_out(6, "t2");
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("t2_out_stable", {30'd0, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_err},
               {30'd0, 1'b1, 32'h8000_0004, 32'h0010_0093, 1'b0});
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t2_ar_cycles",  96'(ar_cycles - ar0), 96'd4);
      check("t2_handshakes", 96'(hs_cnt - hs0),    96'd1);
      check("t2_araddr_stable", 96'(ar_unstable),  96'd0);
      mem_ar_stall = 0;

      // Misaligned PC: fault, no memory request
      ar0 = ar_cycles;
      q.push_back('{pc: 32'h8000_0002, inst: 32'h0, err: 1'b1});
      issue_pc(32'h8000_0002);
      wait_out(1, "t3");
      @(posedge clk); #1;
      check("t3_no_arvalid", 96'(ar_cycles - ar0), 96'd0);

      // Error response still carries the data word
      mem_rresp = 2'b10;
      mem_rdata = 32'hDEAD_BEEF;
      q.push_back('{pc: 32'h8000_0008, inst: 32'hDEAD_BEEF, err: 1'b1});
      issue_pc(32'h8000_0008);
      wait_out(3, "t4");
      @(posedge clk); #1;
      mem_rresp = 2'b00;

      // Flush while the AR is stalled: request held, response drained, no output
      mem_ar_stall = 3;
      ar0 = ar_cycles; ov0 = ov_cycles; rh0 = r_hs_cnt; hs0 = hs_cnt;
      issue_pc(32'h8000_000C);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("t5_ar_held",     96'(ar_cycles - ar0), 96'd4);
      check("t5_r_consumed",  96'(r_hs_cnt - rh0),  96'd1);
      check("t5_no_out",      96'(ov_cycles - ov0), 96'd0);
      check("t5_no_hs",       96'(hs_cnt - hs0),    96'd0);
      @(negedge clk);
      check("t5_pc_ready",    {95'd0, bus.pc_ready}, 96'd1);
      @(posedge clk); #1;
      mem_ar_stall = 0;

      // Flush coinciding with out_ready in HOLD
      bus.out_ready = 1'b0;
      mem_rdata     = 32'h0000_0013;
      issue_pc(32'h8000_0020);
      wait_out(3, "t6a");
      hs0 = hs_cnt;
`ifdef IFU_PERF_EN
      perf0 = perf_fetch_cnt;
`endif
      @(posedge clk); #1;
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t6_out_valid_masked", {95'd0, bus.out_valid}, 96'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("t6_pc_ready", {95'd0, bus.pc_ready}, 96'd1);
      check("t6_no_hs",    96'(hs_cnt - hs0),     96'd0);
`ifdef IFU_PERF_EN
      check("t6_perf_unchanged", {64'd0, perf_fetch_cnt}, {64'd0, perf0});
`endif
      @(posedge clk); #1;
      mem_rdata = 32'h00A0_0093;
      q.push_back('{pc: 32'h8000_0010, inst: 32'h00A0_0093, err: 1'b0});
      issue_pc(32'h8000_0010);
      wait_out(3, "t6b");
      @(posedge clk); #1;
`ifdef IFU_PERF_EN
      check("t6_perf_incr", {64'd0, perf_fetch_cnt}, {64'd0, perf0 + 32'd1});
`endif

      // Flush in IDLE blocks acceptance
      ar0 = ar_cycles; ov0 = ov_cycles;
      bus.pc_valid = 1'b1;
      bus.pc       = 32'h8000_0030;
      bus.flush    = 1'b1;
      @(negedge clk);
      check("t7_pc_ready_blocked", {95'd0, bus.pc_ready}, 96'd0);
      @(posedge clk); #1;
      bus.pc_valid = 1'b0;
      bus.flush    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t7_no_ar",  96'(ar_cycles - ar0), 96'd0);
      check("t7_no_out", 96'(ov_cycles - ov0), 96'd0);

      check("queue_drained", 96'(q.size()), 96'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
